// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the two-requester compare arbiter: operand width,
// FSM state encoding and requester index.
package cmp_arbiter_pkg;

  localparam int CMP_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational three-way comparator. Signed mode flips the sign bit so a single
// unsigned compare orders two's-complement values.
module cmp_core
  import cmp_arbiter_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  logic [W-1:0] a_bias, b_bias;

  assign a_bias = {a[W-1] ^ is_signed, a[W-2:0]};
  assign b_bias = {b[W-1] ^ is_signed, b[W-2:0]};

  assign eq = (a == b);
  assign lt = (a_bias < b_bias);
  assign gt = !eq && !lt;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter between two compare requesters. Operands are captured on
// acceptance and compared from registers, so results appear one cycle later.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_signed,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_signed,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_eq,
  output logic         rsp_lt,
  output logic         rsp_gt
);

  state_e       state;
  req_id_t      last_grant;
  req_id_t      id_q;
  logic [W-1:0] a_q, b_q;
  logic         signed_q;
  logic         can_accept;
  logic         xfer;
  req_id_t      sel;
  logic         core_eq, core_lt, core_gt;

  assign rsp_valid  = (state == RESP);
  assign can_accept = !rst && ((state == IDLE) || (rsp_valid && rsp_ready));

  // On contention the requester not granted last time wins.
  assign req0_ready = can_accept && req0_valid && (!req1_valid || last_grant == 1'b1);
  assign req1_ready = can_accept && req1_valid && (!req0_valid || last_grant == 1'b0);
  assign xfer       = req0_ready || req1_ready;
  assign sel        = req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      signed_q   <= 1'b0;
    end else begin
      if (xfer) begin
        state      <= RESP;
        last_grant <= sel;
        id_q       <= sel;
        a_q        <= sel ? req1_a      : req0_a;
        b_q        <= sel ? req1_b      : req0_b;
        signed_q   <= sel ? req1_signed : req0_signed;
      end else if (state == RESP && rsp_ready) begin
        state <= IDLE;
      end
    end
  end

  cmp_core #(.W(W)) u_core (
    .a         (a_q),
    .b         (b_q),
    .is_signed (signed_q),
    .eq        (core_eq),
    .lt        (core_lt),
    .gt        (core_gt)
  );

  assign rsp_id = id_q;
  assign rsp_eq = rsp_valid && core_eq;
  assign rsp_lt = rsp_valid && core_lt;
  assign rsp_gt = rsp_valid && core_gt;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: compare results, round-robin order,
// backpressure hold and reset in RESP.
module tb_cmp_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_signed;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_signed;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_eq, rsp_lt, rsp_gt;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  cmp_arbiter #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_signed (req0_signed),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_signed (req1_signed),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_eq      (rsp_eq),
    .rsp_lt      (rsp_lt),
    .rsp_gt      (rsp_gt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rsp fields packed as {valid, id, eq, lt, gt}
  task automatic chk_rsp(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt}, {27'd0, exp});
  endtask

  task automatic chk_rdy(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, req1_ready, req0_ready}, {30'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_signed = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_signed = 1'b0;
    #1;
    chk_rdy("rdy_in_rst", 2'b00);
    tick(); tick();
    chk_rsp("reset_state", 5'b0_0_000);
    chk_rdy("rdy_in_rst2", 2'b00);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk_rdy("idle_no_req", 2'b00);

    // req0 alone, back-to-back stream of four compares
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1; req0_signed = 1'b1;
    #1 chk_rdy("r0_only_rdy", 2'b01);
    tick();
    chk_rsp("s_neg1_lt_1", 5'b1_0_010);
    req0_signed = 1'b0;
    #1 chk_rdy("b2b_rdy", 2'b01);
    tick();
    chk_rsp("u_max_gt_1", 5'b1_0_001);
    req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_signed = 1'b1;
    tick();
    chk_rsp("s_min_eq", 5'b1_0_100);
    req0_signed = 1'b0;
    tick();
    chk_rsp("u_min_eq", 5'b1_0_100);
    req0_valid = 1'b0;
    tick();
    chk_rsp("back_to_idle", 5'b0_0_000);

    // req1 alone: signed min below signed max, then unsigned view flips it
    req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'h7FFF_FFFF; req1_signed = 1'b1;
    #1 chk_rdy("r1_only_rdy", 2'b10);
    tick();
    chk_rsp("s_min_lt_max", 5'b1_1_010);
    req1_signed = 1'b0;
    tick();
    chk_rsp("u_8000_gt_7fff", 5'b1_1_001);
    req1_valid = 1'b0;
    tick();
    chk_rsp("idle2", 5'b0_1_000);

    // contention: last grant was 1, so 0,1,0,1
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_signed = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd2; req1_signed = 1'b1;
    #1 chk_rdy("rr_g0", 2'b01);
    tick();
    chk_rsp("rr_rsp0", 5'b1_0_010);
    chk_rdy("rr_g1", 2'b10);
    tick();
    chk_rsp("rr_rsp1", 5'b1_1_001);
    chk_rdy("rr_g2", 2'b01);
    tick();
    chk_rsp("rr_rsp2", 5'b1_0_010);
    chk_rdy("rr_g3", 2'b10);
    tick();
    chk_rsp("rr_rsp3", 5'b1_1_001);

    // backpressure: output frozen, no grants
    rsp_ready = 1'b0;
    req0_a = 32'd4; req0_b = 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1 chk_rdy("hold_rdy", 2'b00);
      tick();
      chk_rsp("hold_rsp", 5'b1_1_001);
    end
    rsp_ready = 1'b1;
    #1 chk_rdy("release_rdy", 2'b01);
    tick();
    chk_rsp("release_rsp", 5'b1_0_100);

    // reset while holding a result
    rst = 1'b1;
    #1 chk_rdy("rst_resp_rdy", 2'b00);
    tick();
    chk_rsp("rst_resp_rsp", 5'b0_0_000);
    rst = 1'b0;
    #1 chk_rdy("post_rst_g0", 2'b01);
    tick();
    chk_rsp("post_rst_rsp", 5'b1_0_100);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk_rsp("final_idle", 5'b0_0_000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter: W, 32, operand width in bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 (branch unit) has a compare pending.
REQ-005 Port: req0_ready  output  1  requester 0 is accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 Port: req0_signed  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_signed  same widths and meaning as REQ-004..007, requester 1 (ALU SLT/SLTU).
REQ-009 Port: rsp_valid  output  1  a compare result is presented.
REQ-010 Port: rsp_ready  input  1  the consumer accepts the result.
REQ-011 Port: rsp_id  output  1  index of the requester that owns the result.
REQ-012 Port: rsp_eq, rsp_lt, rsp_gt  output  1 each  a==b, a<b, a>b under the captured signedness.

Function
REQ-013 The block SHALL be a two-state FSM: IDLE (no result held) and RESP (result held, rsp_valid=1).
REQ-014 Request handshake: transfer when reqN_valid && reqN_ready; valid SHALL NOT depend on ready.
REQ-015 can_accept = (state==IDLE) || (rsp_valid && rsp_ready); reqN_ready SHALL be 0 unless can_accept.
REQ-016 Only one requester SHALL be granted per cycle; at most one reqN_ready is 1.
REQ-017 Single requester valid -> that requester is granted when can_accept.
REQ-018 Both valid -> grant the requester that was not granted most recently (round-robin); last_grant updates only on a transfer.
REQ-019 On a transfer: a, b, signed and the requester index SHALL be registered; state -> RESP.
REQ-020 Latency: rsp_valid SHALL rise exactly one cycle after the accepting edge, with results for the captured operands.
REQ-021 RESP with rsp_ready=1 and no new transfer -> IDLE; with a new transfer -> remains RESP, new result next cycle (back-to-back, 1 result/cycle).
REQ-022 RESP with rsp_ready=0 -> rsp_valid, rsp_id, rsp_eq/lt/gt SHALL stay stable and both reqN_ready SHALL be 0.
REQ-023 Exactly one of rsp_eq/rsp_lt/rsp_gt SHALL be 1 while rsp_valid=1.
REQ-024 Signed compare: MSB is the sign; negative < non-negative; same signs compare by magnitude ordering of the raw bits; 0x80000000 is the minimum.
REQ-025 Unsigned compare: plain magnitude order of the W-bit values.
REQ-026 rsp_eq SHALL be independent of signedness.
REQ-027 In IDLE, rsp_eq/lt/gt SHALL be 0.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, rsp_valid=0, rsp_id=0, rsp_eq=rsp_lt=rsp_gt=0, last_grant=1 (requester 0 wins the first contention).
REQ-029 reqN_ready SHALL be 0 in every cycle rst=1.
REQ-030 Reset during RESP SHALL discard the held result; no response is produced for it.

Structure
REQ-031 A shared package SHALL hold CMP_W (default 32), the FSM state enum {IDLE, RESP} and the requester-index type.
REQ-032 The magnitude/sign comparison SHALL be one sub-module, cmp_core (inputs a, b, is_signed; outputs eq, lt, gt, purely combinational), fed from the captured operand registers.
REQ-033 No combinational path SHALL exist from reqN_a/b to any rsp_* output.

Verification
REQ-034 req0 only, signed=1, a=0xFFFFFFFF, b=0x00000001 -> next cycle rsp_valid=1, rsp_id=0, lt=1.
REQ-035 Same operands, signed=0 -> gt=1; a=b=0x80000000 either mode -> eq=1.
REQ-036 Both requesters valid continuously, rsp_ready=1 -> grants 0,1,0,1, one rsp_valid per cycle, rsp_id alternating.
REQ-037 rsp_ready=0 for 3 cycles with both valid -> rsp_* frozen, both reqN_ready=0; rsp_ready=1 -> next grant follows round-robin.
REQ-038 rst=1 in RESP -> next cycle rsp_valid=0, all outputs 0; after release, first contention grants requester 0.
